// File: rtl/spi_pkg.sv
// spi_pkg: shared state encoding and widths for the byte-wide SPI master
package spi_pkg;
   localparam int SPI_BYTE_W   = 8;
   localparam int SPI_BITCNT_W = 3;
   localparam int SPI_DIV_W    = 8;
   typedef enum logic [2:0] {IDLE, LOW, HIGH, DONE, NEXT, HOLD, GAP} spi_state_e;
endpackage

// File: rtl/spi_half_tick.sv
// spi_half_tick: reloading down-counter, tc_o high for one cycle every load_i cycles after clr_i
module spi_half_tick
   import spi_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 clr_i,
   input  logic [SPI_DIV_W-1:0] load_i,
   output logic                 tc_o
);
   logic [SPI_DIV_W-1:0] cnt_q, cnt_d;
   assign tc_o = (cnt_q == '0);
   // reload on clear or on terminal count so every state entry restarts a full period
   always_comb cnt_d = (clr_i || tc_o) ? load_i - 1'b1 : cnt_q - 1'b1;
   // counter register
   always_ff @(posedge clk) cnt_q <= rst ? '0 : cnt_d;
endmodule

// File: rtl/spi_master_byte.sv
// spi_master_byte: mode-0 MSB-first SPI master; SPI_MISO_SYNC_EN adds a 2-flop MISO synchroniser
module spi_master_byte
   import spi_pkg::*;
#(
   parameter int CLK_DIV  = 4,
   parameter int IDLE_GAP = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  tx_valid,
   output logic                  tx_ready,
   input  logic [SPI_BYTE_W-1:0] tx_data,
   input  logic                  tx_last,
   output logic                  rx_valid,
   output logic [SPI_BYTE_W-1:0] rx_data,
   output logic                  busy,
   output logic                  SCK,
   output logic                  SSEL,
   output logic                  MOSI,
   input  logic                  MISO
);
   spi_state_e              state_q;
   logic [SPI_BYTE_W-1:0]   tx_q, rx_sh_q;
   logic [SPI_BITCNT_W-1:0] bit_q;
   logic                    last_q, div_tc, gap_tc, accept, miso_s;
   assign tx_ready = !rst && (state_q == IDLE || state_q == NEXT);
   assign accept   = tx_valid && tx_ready;
`ifdef SPI_MISO_SYNC_EN
   if (CLK_DIV < 3) begin : g_div_chk
      $error("CLK_DIV must be >= 3 when SPI_MISO_SYNC_EN is defined");
   end
   logic [1:0] miso_sync_q;
   // two-flop synchroniser; the SCK-rise sample sees MISO from two cycles earlier
   always_ff @(posedge clk) miso_sync_q <= rst ? 2'b00 : {miso_sync_q[0], MISO};
   assign miso_s = miso_sync_q[1];
`else
   assign miso_s = MISO;
`endif
   spi_half_tick u_div (
      .clk(clk), .rst(rst), .clr_i(accept),
      .load_i(SPI_DIV_W'(CLK_DIV)), .tc_o(div_tc)
   );
   spi_half_tick u_gap (
      .clk(clk), .rst(rst), .clr_i(state_q == HOLD && div_tc),
      .load_i(SPI_DIV_W'(IDLE_GAP)), .tc_o(gap_tc)
   );
   // frame sequencer: SCK phases, MOSI shifting, MISO capture and SSEL framing
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         SCK      <= 1'b0;
         SSEL     <= 1'b1;
         MOSI     <= 1'b0;
         rx_valid <= 1'b0;
         rx_data  <= '0;
         busy     <= 1'b0;
         tx_q     <= '0;
         rx_sh_q  <= '0;
         bit_q    <= '0;
         last_q   <= 1'b0;
      end else begin
         rx_valid <= 1'b0;
         case (state_q)
            IDLE, NEXT: if (accept) begin
               state_q <= LOW;
               SSEL    <= 1'b0;
               SCK     <= 1'b0;
               MOSI    <= tx_data[SPI_BYTE_W-1];
               tx_q    <= {tx_data[SPI_BYTE_W-2:0], 1'b0};
               last_q  <= tx_last;
               bit_q   <= '0;
               busy    <= 1'b1;
            end
            LOW: if (div_tc) begin
               state_q <= HIGH;
               SCK     <= 1'b1;
               rx_sh_q <= {rx_sh_q[SPI_BYTE_W-2:0], miso_s};
            end
            HIGH: if (div_tc) begin
               SCK   <= 1'b0;
               bit_q <= bit_q + 1'b1;
               if (bit_q == '1) begin
                  state_q  <= DONE;
                  rx_valid <= 1'b1;
                  rx_data  <= rx_sh_q;
               end else begin
                  state_q <= LOW;
                  MOSI    <= tx_q[SPI_BYTE_W-1];
                  tx_q    <= {tx_q[SPI_BYTE_W-2:0], 1'b0};
               end
            end
            DONE: state_q <= last_q ? HOLD : NEXT;
            HOLD: if (div_tc) begin
               state_q <= GAP;
               SSEL    <= 1'b1;
               MOSI    <= 1'b0;
            end
            GAP: if (gap_tc) begin
               state_q <= IDLE;
               busy    <= 1'b0;
            end
            default: state_q <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_spi_master_byte.sv
// tb_spi_master_byte: randomized self-checking bench with a behavioural SPI slave
module tb_spi_master_byte;
`ifdef SPI_MISO_SYNC_EN
   localparam int D = 3;
`else
   localparam int D = 4;
`endif
   localparam int G = 4;
   logic clk = 1'b0, rst = 1'b1, tx_valid = 1'b0, tx_last = 1'b0, loop_en = 1'b0;
   logic [7:0] tx_data = 8'h00, sl_byte = 8'h00;
   logic [2:0] sl_idx = 3'd0;
   logic tx_ready, rx_valid, busy, SCK, SSEL, MOSI, MISO;
   logic [7:0] rx_data;
   int tests = 0, fails = 0;
   always #5 clk = ~clk;
   assign MISO = loop_en ? MOSI : sl_byte[~sl_idx];
   always @(posedge SCK or posedge SSEL) sl_idx <= SSEL ? 3'd0 : sl_idx + 3'd1;
   spi_master_byte #(.CLK_DIV(D), .IDLE_GAP(G)) dut (
      .clk(clk), .rst(rst), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .tx_data(tx_data), .tx_last(tx_last), .rx_valid(rx_valid), .rx_data(rx_data),
      .busy(busy), .SCK(SCK), .SSEL(SSEL), .MOSI(MOSI), .MISO(MISO)
   );
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   task automatic wait_ready;
      int n = 0;
      while (!tx_ready && n < 400) begin
         tick;
         n++;
      end
      if (!tx_ready) begin
         tests++;
         fails++;
         $display("FAIL ready_timeout: tx_ready=%b required 1", tx_ready);
      end
   endtask
   task automatic xfer(input logic [7:0] d, input logic last, input logic [7:0] s,
                       output logic [7:0] mo, output logic [7:0] rx, output logic hi);
      int n = 0;
      logic pk = 1'b0;
      mo = 8'h00;
      wait_ready;
      sl_byte = s;
      tx_valid = 1'b1;
      tx_data = d;
      tx_last = last;
      hi = SSEL;
      tick;
      tx_valid = 1'b0;
      tx_data = 8'($urandom);
      tx_last = 1'($urandom);
      while (!rx_valid && n < 40 * D) begin
         hi = hi | SSEL;
         if (SCK && !pk) mo = {mo[6:0], MOSI};
         pk = SCK;
         tick;
         n++;
      end
      if (!rx_valid) begin
         tests++;
         fails++;
         $display("FAIL rx_timeout: rx_valid=%b required 1", rx_valid);
      end
      rx = rx_data;
   endtask
   task automatic test_reset;
      rst = 1'b1;
      repeat (3) tick;
      tests += 7;
      if (SCK !== 1'b0) begin fails++; $display("FAIL rst_sck: got %b want 0", SCK); end
      if (SSEL !== 1'b1) begin fails++; $display("FAIL rst_ssel: got %b want 1", SSEL); end
      if (MOSI !== 1'b0) begin fails++; $display("FAIL rst_mosi: got %b want 0", MOSI); end
      if (rx_valid !== 1'b0) begin fails++; $display("FAIL rst_rxv: got %b want 0", rx_valid); end
      if (rx_data !== 8'h00) begin fails++; $display("FAIL rst_rxd: got %h want 00", rx_data); end
      if (busy !== 1'b0) begin fails++; $display("FAIL rst_busy: got %b want 0", busy); end
      if (tx_ready !== 1'b0) begin fails++; $display("FAIL rst_ready: got %b want 0", tx_ready); end
      rst = 1'b0;
      tick;
      tests++;
      if (tx_ready !== 1'b1) begin fails++; $display("FAIL idle_ready: got %b want 1", tx_ready); end
   endtask
   task automatic test_single_byte;
      logic [7:0] d = 8'hA5;
      logic [7:0] s = 8'($urandom);
      logic sck_e, mosi_e, ssel_e, rxv_e, rdy_e, busy_e;
      int ph;
      wait_ready;
      sl_byte = s;
      tx_valid = 1'b1;
      tx_data = d;
      tx_last = 1'b1;
      tick;
      tx_valid = 1'b0;
      for (int c = 1; c <= 17 * D + G + 3; c++) begin
         ph = c - 1;
         sck_e = (c <= 16 * D) && ((ph % (2 * D)) >= D);
         mosi_e = (c <= 16 * D) ? d[7 - ph / (2 * D)] : (c < 1 + 17 * D) ? d[0] : 1'b0;
         ssel_e = (c >= 1 + 17 * D);
         rxv_e = (c == 1 + 16 * D);
         rdy_e = (c >= 1 + 17 * D + G);
         busy_e = !rdy_e;
         tests += 6;
         if (SCK !== sck_e) begin fails++; $display("FAIL sb_sck c=%0d: got %b want %b", c, SCK, sck_e); end
         if (MOSI !== mosi_e) begin fails++; $display("FAIL sb_mosi c=%0d: got %b want %b", c, MOSI, mosi_e); end
         if (SSEL !== ssel_e) begin fails++; $display("FAIL sb_ssel c=%0d: got %b want %b", c, SSEL, ssel_e); end
         if (rx_valid !== rxv_e) begin fails++; $display("FAIL sb_rxv c=%0d: got %b want %b", c, rx_valid, rxv_e); end
         if (tx_ready !== rdy_e) begin fails++; $display("FAIL sb_ready c=%0d: got %b want %b", c, tx_ready, rdy_e); end
         if (busy !== busy_e) begin fails++; $display("FAIL sb_busy c=%0d: got %b want %b", c, busy, busy_e); end
         if (rxv_e) begin
            tests++;
            if (rx_data !== s) begin fails++; $display("FAIL sb_rxd: got %h want %h", rx_data, s); end
         end
         tick;
      end
   endtask
   task automatic test_loopback;
      logic [7:0] bytes [3] = '{8'h3C, 8'hFF, 8'h00};
      logic [7:0] mo, rx;
      logic hi;
      loop_en = 1'b1;
      for (int i = 0; i < 3; i++) begin
         xfer(bytes[i], i == 2, 8'h00, mo, rx, hi);
         tests += 2;
         if (rx !== bytes[i]) begin fails++; $display("FAIL lb_rx%0d: got %h want %h", i, rx, bytes[i]); end
         if (hi !== (i == 0)) begin fails++; $display("FAIL lb_ssel%0d: got %b want %b", i, hi, i == 0); end
      end
      for (int i = 0; i < 8; i++) begin
         logic [7:0] d = 8'($urandom);
         xfer(d, 1'($urandom), 8'h00, mo, rx, hi);
         tests++;
         if (rx !== d) begin fails++; $display("FAIL lb_rnd%0d: got %h want %h", i, rx, d); end
      end
      xfer(8'h5A, 1'b1, 8'h00, mo, rx, hi);
      loop_en = 1'b0;
   endtask
   task automatic test_stall;
      logic [7:0] d0 = 8'($urandom), d1 = 8'($urandom), s0 = 8'($urandom), s1 = 8'($urandom);
      logic [7:0] mo, rx;
      logic hi;
      xfer(d0, 1'b0, s0, mo, rx, hi);
      tests += 2;
      if (rx !== s0) begin fails++; $display("FAIL st_rx0: got %h want %h", rx, s0); end
      if (mo !== d0) begin fails++; $display("FAIL st_mo0: got %h want %h", mo, d0); end
      tick;
      for (int c = 0; c < 50; c++) begin
         tests += 3;
         if (SCK !== 1'b0) begin fails++; $display("FAIL st_sck c=%0d: got %b want 0", c, SCK); end
         if (SSEL !== 1'b0) begin fails++; $display("FAIL st_ssel c=%0d: got %b want 0", c, SSEL); end
         if (tx_ready !== 1'b1) begin fails++; $display("FAIL st_ready c=%0d: got %b want 1", c, tx_ready); end
         tick;
      end
      xfer(d1, 1'b1, s1, mo, rx, hi);
      tests += 3;
      if (rx !== s1) begin fails++; $display("FAIL st_rx1: got %h want %h", rx, s1); end
      if (mo !== d1) begin fails++; $display("FAIL st_mo1: got %h want %h", mo, d1); end
      if (hi !== 1'b0) begin fails++; $display("FAIL st_cont: got %b want 0", hi); end
   endtask
   task automatic test_reset_mid;
      logic [7:0] s = 8'($urandom);
      logic [7:0] mo, rx;
      logic hi, pk = 1'b0, seen = 1'b0;
      int rises = 0, n = 0;
      wait_ready;
      tx_valid = 1'b1;
      tx_data = 8'($urandom);
      tx_last = 1'b1;
      tick;
      tx_valid = 1'b0;
      while (rises < 4 && n < 20 * D) begin
         if (SCK && !pk) rises++;
         pk = SCK;
         if (rises < 4) tick;
         n++;
      end
      rst = 1'b1;
      tick;
      tests += 4;
      if (SSEL !== 1'b1) begin fails++; $display("FAIL rm_ssel: got %b want 1", SSEL); end
      if (SCK !== 1'b0) begin fails++; $display("FAIL rm_sck: got %b want 0", SCK); end
      if (MOSI !== 1'b0) begin fails++; $display("FAIL rm_mosi: got %b want 0", MOSI); end
      if (busy !== 1'b0) begin fails++; $display("FAIL rm_busy: got %b want 0", busy); end
      rst = 1'b0;
      for (int c = 0; c < 20 * D; c++) begin
         seen = seen | rx_valid;
         tick;
      end
      tests++;
      if (seen !== 1'b0) begin fails++; $display("FAIL rm_rxv: got %b want 0", seen); end
      xfer(8'h81, 1'b1, s, mo, rx, hi);
      tests += 3;
      if (mo !== 8'h81) begin fails++; $display("FAIL rm_mo: got %h want 81", mo); end
      if (rx !== s) begin fails++; $display("FAIL rm_rx: got %h want %h", rx, s); end
      if (hi !== 1'b1) begin fails++; $display("FAIL rm_new_msg: got %b want 1", hi); end
   endtask
   task automatic test_led;
      logic [7:0] cnt = 8'($urandom);
      logic [7:0] mo, rx;
      logic hi, led;
      xfer(8'h01, 1'b1, cnt, mo, rx, hi);
      led = mo[0];
      tests += 2;
      if (led !== 1'b1) begin fails++; $display("FAIL led_on: got %b want 1", led); end
      if (rx !== cnt) begin fails++; $display("FAIL led_cnt0: got %h want %h", rx, cnt); end
      cnt = cnt + 8'd1;
      xfer(8'h00, 1'b1, cnt, mo, rx, hi);
      led = mo[0];
      tests += 2;
      if (led !== 1'b0) begin fails++; $display("FAIL led_off: got %b want 0", led); end
      if (rx !== cnt) begin fails++; $display("FAIL led_cnt1: got %h want %h", rx, cnt); end
   endtask
   task automatic test_random;
      logic [7:0] d, s, mo, rx;
      logic hi, last, prev_last = 1'b1;
      wait_ready;
      for (int i = 0; i < 30; i++) begin
         d = 8'($urandom);
         s = 8'($urandom);
         last = ($urandom_range(0, 3) == 0);
         repeat ($urandom_range(0, 5)) tick;
         xfer(d, last, s, mo, rx, hi);
         tests += 3;
         if (mo !== d) begin fails++; $display("FAIL rnd_mo%0d: got %h want %h", i, mo, d); end
         if (rx !== s) begin fails++; $display("FAIL rnd_rx%0d: got %h want %h", i, rx, s); end
         if (hi !== prev_last) begin fails++; $display("FAIL rnd_frame%0d: got %b want %b", i, hi, prev_last); end
         prev_last = last;
      end
   endtask
   initial begin
      test_reset;
      test_single_byte;
      test_loopback;
      test_stall;
      test_reset_mid;
      test_led;
      test_random;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/spi_master_byte.md
Name: spi_master_byte

Overview:
- FPGA-side SPI master (mode 0, MSB first, active-low SSEL) that drives the SCK/SSEL/MOSI/MISO bus of the on-chip SPI slave stage.
- Converts a valid/ready byte stream into SPI frames and returns each byte received on MISO as a one-cycle rx pulse.
- `tx_last` groups bytes into a single SSEL-low message.
- SCK timing is slow enough for a slave that oversamples SCK through a 3-flop synchroniser on the same `clk`.

Parameters:
- CLK_DIV, 4, clk cycles per SCK half-period; legal range 2..255.
- IDLE_GAP, 4, minimum clk cycles SSEL stays high between messages; minimum 2.

Ports:
- clk  in  1  system clock, all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- tx_valid  in  1  `tx_data`/`tx_last` valid.
- tx_ready  out  1  block accepts a byte this cycle.
- tx_data  in  8  byte to send, MSB first.
- tx_last  in  1  deassert SSEL after this byte.
- rx_valid  out  1  one-cycle pulse, `rx_data` valid.
- rx_data  out  8  byte shifted in from MISO.
- busy  out  1  high from accept of the first byte until the end of the IDLE_GAP.
- SCK  out  1  SPI clock, idles low.
- SSEL  out  1  slave select, active low.
- MOSI  out  1  master data out.
- MISO  in  1  slave data in.

Behaviour:
- All outputs are registered. Reset values: SCK=0, SSEL=1, MOSI=0, rx_valid=0, rx_data=0x00, busy=0.
- tx_ready is decoded from state: 0 while rst is high, 1 in IDLE and NEXT, 0 in all other states.
- States:
  - IDLE: SSEL=1, tx_ready=1. Accept goes to LOW.
  - LOW: SCK=0, holding for CLK_DIV cycles, then goes to HIGH with SCK<=1.
  - HIGH: holding for CLK_DIV cycles, then SCK<=0. If bits remain, go to LOW; after bit 8, go to DONE.
  - DONE: one cycle, rx_valid=1. Go to NEXT (tx_last=0) or HOLD (tx_last=1).
  - NEXT: SSEL=0, SCK=0, tx_ready=1. The bus stalls indefinitely here. Accept goes to LOW.
  - HOLD: SSEL=0 for CLK_DIV cycles, then SSEL<=1 and go to GAP.
  - GAP: SSEL=1 for IDLE_GAP cycles, then go to IDLE with busy<=0.
- Accept (`tx_valid && tx_ready`) at cycle T:
  - At T+1: SSEL=0, MOSI=tx_data[7], busy=1. `tx_data` and `tx_last` are latched.
- SCK rising edges occur at T+1+CLK_DIV+2·CLK_DIV·k, for k=0..7.
- At the clk edge that raises SCK, the sampled MISO shifts into the rx shift register LSB.
- At each SCK falling edge except after bit 8, MOSI advances to the next lower bit.
- After bit 8's high phase, SCK falls and the FSM enters DONE. rx_data updates in that same cycle.
- Bit counter: 3 bits. It wraps 7->0 at DONE and is reloaded on every accept.
- The divider counter is cleared at every state entry.
- Simultaneous events:
  - tx_valid in DONE is ignored, since tx_ready=0.
  - tx_valid held in NEXT is accepted in the first NEXT cycle.
- MISO is not sampled and rx_valid never pulses outside HIGH/DONE.
- rst mid-transfer:
  - Next cycle: SSEL=1, SCK=0, MOSI=0, state=IDLE.
  - The partial byte is discarded and no rx_valid is emitted.
  - The slave's bit counter clears on SSEL high.
- MOSI holds its last bit while SSEL is low and idle. It is 0 when SSEL=1.

Optional Feature:
- SPI_MISO_SYNC_EN defined:
  - MISO passes through a 2-flop synchroniser before sampling.
  - The sample point stays at the SCK rising edge, using the value registered 2 cycles earlier.
  - Requires CLK_DIV ≥ 3. Elaborate-time error otherwise.
- Undefined: MISO is sampled directly, for the same-clock-domain slave.

Decomposition:
- Package spi_pkg holds:
  - the state enum (IDLE, LOW, HIGH, DONE, NEXT, HOLD, GAP);
  - SPI_BYTE_W=8;
  - SPI_BITCNT_W=3;
  - SPI_DIV_W=8.
- Sub-module spi_half_tick: a CLK_DIV down-counter with a clear input and a one-cycle terminal-count output, used for LOW/HIGH/HOLD timing.
- The GAP timer reuses spi_half_tick, loaded with IDLE_GAP.

Test Plan:
- Single-byte message (CLK_DIV=4):
  - Stimulus: tx_data=0xA5, tx_last=1, accepted at cycle 0.
  - Response: SSEL low at cycle 1; SCK rises at 5, 13, …, 61; MOSI bits 1,0,1,0,0,1,0,1.
  - Response: rx_valid at cycle 65; SSEL high at cycle 69; tx_ready=1 at cycle 73.
- Loopback (MISO tied to MOSI): tx 0x3C, 0xFF, 0x00, tx_last on the third byte -> rx_data 0x3C, 0xFF, 0x00, with SSEL low throughout all three bytes.
- LED slave end-to-end:
  - Send 0x01 then 0x00 as two separate messages.
  - Slave LED goes 1 then 0.
  - The first rx byte of each message equals the slave's message counter, incrementing by 1.
- Stall in NEXT: withhold tx_valid for 50 cycles after the first byte -> SCK stays 0, SSEL stays 0, tx_ready stays 1; resuming continues the same message.
- Reset mid-byte: assert rst during bit 4 -> next cycle SSEL=1, SCK=0, no rx_valid; the following 0x81 message completes correctly.
- SPI_MISO_SYNC_EN build with CLK_DIV=3: repeat the loopback test -> identical rx bytes.
